// File: rtl/cdb_arbiter.sv
// CDB arbiter: per-source result FIFOs, round-robin grant onto one registered broadcast bus.
// Latency >=1 cycle from accept to broadcast; a source's ready drops when its FIFO is full or rdy_in is low.

module cdb_fifo #(
    parameter int W     = 36,
    parameter int DEPTH = 2,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          i_clr,
    input  logic          i_push,
    input  logic [W-1:0]  i_wr_dat,
    input  logic          i_pop,
    output logic [W-1:0]  o_head_dat,
    output logic [AW:0]   o_count
);
    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    // Pointers are AW bits wide, so wrapping modulo DEPTH is free for a power-of-2 depth.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (i_push) r_mem[r_wr_ptr] <= i_wr_dat;
    end

    assign o_head_dat = r_mem[r_rd_ptr];
    assign o_count    = r_count;
endmodule

module cdb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ROB_IDX_W  = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 clr_in,
    input  logic                 alu_req_valid,
    output logic                 alu_req_ready,
    input  logic [ROB_IDX_W-1:0] alu_req_rob_index,
    input  logic [DATA_W-1:0]    alu_req_data,
    input  logic                 lsb_req_valid,
    output logic                 lsb_req_ready,
    input  logic [ROB_IDX_W-1:0] lsb_req_rob_index,
    input  logic [DATA_W-1:0]    lsb_req_data,
    output logic                 cdb_valid,
    output logic [ROB_IDX_W-1:0] cdb_rob_index,
    output logic [DATA_W-1:0]    cdb_data,
    output logic                 cdb_src
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = ROB_IDX_W + DATA_W;
    localparam logic [AW:0] FULL_CNT = FIFO_DEPTH[AW:0];

    logic [AW:0]   w_alu_cnt, w_lsb_cnt;
    logic [EW-1:0] w_alu_head, w_lsb_head, w_head;
    logic          w_run, w_alu_push, w_lsb_push, w_alu_pop, w_lsb_pop;
    logic          w_alu_ne, w_lsb_ne, w_grant_vld, w_grant_src;

    logic                 r_cdb_vld;
    logic [ROB_IDX_W-1:0] r_cdb_rob;
    logic [DATA_W-1:0]    r_cdb_dat;
    logic                 r_cdb_src;
    logic                 r_last_grant;

    assign alu_req_ready = rdy_in && (w_alu_cnt < FULL_CNT);
    assign lsb_req_ready = rdy_in && (w_lsb_cnt < FULL_CNT);

    assign w_run      = rdy_in && !clr_in;
    assign w_alu_push = w_run && alu_req_valid && alu_req_ready;
    assign w_lsb_push = w_run && lsb_req_valid && lsb_req_ready;

    assign w_alu_ne    = (w_alu_cnt != '0);
    assign w_lsb_ne    = (w_lsb_cnt != '0);
    assign w_grant_vld = w_run && (w_alu_ne || w_lsb_ne);
    // On a tie the source that did not win last time gets the bus; otherwise whichever is non-empty.
    assign w_grant_src = (w_alu_ne && w_lsb_ne) ? ~r_last_grant : w_lsb_ne;
    assign w_alu_pop   = w_grant_vld && !w_grant_src;
    assign w_lsb_pop   = w_grant_vld &&  w_grant_src;
    assign w_head      = w_grant_src ? w_lsb_head : w_alu_head;

    cdb_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_alu_fifo (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .i_clr      (clr_in),
        .i_push     (w_alu_push),
        .i_wr_dat   ({alu_req_rob_index, alu_req_data}),
        .i_pop      (w_alu_pop),
        .o_head_dat (w_alu_head),
        .o_count    (w_alu_cnt)
    );

    cdb_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_lsb_fifo (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .i_clr      (clr_in),
        .i_push     (w_lsb_push),
        .i_wr_dat   ({lsb_req_rob_index, lsb_req_data}),
        .i_pop      (w_lsb_pop),
        .o_head_dat (w_lsb_head),
        .o_count    (w_lsb_cnt)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_cdb_vld    <= 1'b0;
            r_cdb_rob    <= '0;
            r_cdb_dat    <= '0;
            r_cdb_src    <= 1'b0;
            r_last_grant <= 1'b1;
        end else if (clr_in) begin
            r_cdb_vld    <= 1'b0;
            r_cdb_rob    <= '0;
            r_cdb_dat    <= '0;
            r_cdb_src    <= 1'b0;
            r_last_grant <= 1'b1;
        end else if (rdy_in) begin
            r_cdb_vld <= w_grant_vld;
            if (w_grant_vld) begin
                r_cdb_rob <= w_head[EW-1:DATA_W];
                r_cdb_dat <= w_head[DATA_W-1:0];
                r_cdb_src <= w_grant_src;
            end
            if (w_alu_ne && w_lsb_ne) r_last_grant <= w_grant_src;
        end
    end

    assign cdb_valid     = r_cdb_vld;
    assign cdb_rob_index = r_cdb_rob;
    assign cdb_data      = r_cdb_dat;
    assign cdb_src       = r_cdb_src;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: expected broadcasts are queued by the stimulus, a negedge monitor pops and compares.
module tb_cdb_arbiter;
    localparam int DW = 32;
    localparam int RW = 4;

    logic          clk = 1'b0;
    logic          rst, rdy, clr;
    logic          a_v, l_v;
    logic [RW-1:0] a_rob, l_rob;
    logic [DW-1:0] a_dat, l_dat;
    logic          alu_req_ready, lsb_req_ready;
    logic          cdb_valid, cdb_src;
    logic [RW-1:0] cdb_rob_index;
    logic [DW-1:0] cdb_data;

    typedef struct packed {
        logic [RW-1:0] rob;
        logic [DW-1:0] dat;
        logic          src;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   vectors     = 0;
    int   miscompares = 0;
    bit   upd         = 1'b0;

    logic [RW-1:0] ar[4], lr[4];
    logic [DW-1:0] ad[4], ld[4];
    int            ai, li, an, ln;

    always #5 clk = ~clk;

    cdb_arbiter #(.DATA_W(DW), .ROB_IDX_W(RW), .FIFO_DEPTH(2)) dut (
        .clk_in            (clk),
        .rst_in            (rst),
        .rdy_in            (rdy),
        .clr_in            (clr),
        .alu_req_valid     (a_v),
        .alu_req_ready     (alu_req_ready),
        .alu_req_rob_index (a_rob),
        .alu_req_data      (a_dat),
        .lsb_req_valid     (l_v),
        .lsb_req_ready     (lsb_req_ready),
        .lsb_req_rob_index (l_rob),
        .lsb_req_data      (l_dat),
        .cdb_valid         (cdb_valid),
        .cdb_rob_index     (cdb_rob_index),
        .cdb_data          (cdb_data),
        .cdb_src           (cdb_src)
    );

    always @(posedge clk) begin
        if (!rst && a_v && alu_req_ready) assert (a_rob != '0) else $error("protocol: ALU pushed rob_index 0");
        if (!rst && l_v && lsb_req_ready) assert (l_rob != '0) else $error("protocol: LSB pushed rob_index 0");
    end

    // A broadcast is new only if the preceding edge was allowed to update state.
    always @(posedge clk) upd = rdy && !rst;

    always @(negedge clk) begin
        if (cdb_valid && upd) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL sb_unexpected: got rob=%0d data=0x%0h src=%0d, expected no broadcast",
                         cdb_rob_index, cdb_data, cdb_src);
            end else begin
                mon_e = sb.pop_front();
                if ({cdb_rob_index, cdb_data, cdb_src} !== mon_e) begin
                    miscompares++;
                    $display("FAIL sb_bcast: got rob=%0d data=0x%0h src=%0d, expected rob=%0d data=0x%0h src=%0d",
                             cdb_rob_index, cdb_data, cdb_src, mon_e.rob, mon_e.dat, mon_e.src);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_bc(input logic [RW-1:0] rob, input logic [DW-1:0] dat, input logic src);
        exp_t e;
        e.rob = rob;
        e.dat = dat;
        e.src = src;
        sb.push_back(e);
    endtask

    task automatic setup(input int abase, input int lbase, input int na, input int nl);
        for (int i = 0; i < 4; i++) begin
            ar[i] = RW'(abase + i);
            ad[i] = 32'hA000 + DW'(abase + i);
            lr[i] = RW'(lbase + i);
            ld[i] = 32'hB000 + DW'(lbase + i);
        end
        ai = 0; li = 0; an = na; ln = nl;
    endtask

    // One clock of handshake-driven stimulus; ends 1 time unit after the edge.
    task automatic cyc();
        bit fa, fl;
        a_v = (ai < an);
        l_v = (li < ln);
        if (ai < an) begin a_rob = ar[ai]; a_dat = ad[ai]; end
        if (li < ln) begin l_rob = lr[li]; l_dat = ld[li]; end
        #1;
        fa = a_v && alu_req_ready;
        fl = l_v && lsb_req_ready;
        @(posedge clk);
        #1;
        if (fa) ai++;
        if (fl) li++;
    endtask

    task automatic do_reset(input string tname);
        chk({"sb_drained_", tname}, 64'(sb.size()), 64'd0);
        rst = 1'b1; rdy = 1'b1; clr = 1'b0;
        a_v = 1'b0; l_v = 1'b0;
        a_rob = '0; l_rob = '0; a_dat = '0; l_dat = '0;
        ai = 0; li = 0; an = 0; ln = 0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset("init");
        chk("rst_valid", 64'(cdb_valid), 64'd0);
        chk("rst_rob",   64'(cdb_rob_index), 64'd0);
        chk("rst_data",  64'(cdb_data), 64'd0);
        chk("rst_src",   64'(cdb_src), 64'd0);
        chk("rst_alu_ready", 64'(alu_req_ready), 64'd1);
        chk("rst_lsb_ready", 64'(lsb_req_ready), 64'd1);

        // Single ALU result
        setup(5, 1, 1, 0);
        ad[0] = 32'h11;
        expect_bc(4'd5, 32'h11, 1'b0);
        cyc(); chk("single_e1_valid", 64'(cdb_valid), 64'd0);
        cyc(); chk("single_e2_valid", 64'(cdb_valid), 64'd1);
        chk("single_e2_rob", 64'(cdb_rob_index), 64'd5);
        chk("single_e2_data", 64'(cdb_data), 64'h11);
        chk("single_e2_src", 64'(cdb_src), 64'd0);
        cyc(); chk("single_e3_valid", 64'(cdb_valid), 64'd0);

        // Simultaneous pushes from reset: ALU wins the first tie
        do_reset("single");
        setup(3, 7, 1, 1);
        ad[0] = 32'hA; ld[0] = 32'hB;
        expect_bc(4'd3, 32'hA, 1'b0);
        expect_bc(4'd7, 32'hB, 1'b1);
        cyc();
        cyc(); chk("tie_e2_src", 64'(cdb_src), 64'd0);
        chk("tie_e2_rob", 64'(cdb_rob_index), 64'd3);
        cyc(); chk("tie_e3_src", 64'(cdb_src), 64'd1);
        chk("tie_e3_valid", 64'(cdb_valid), 64'd1);
        cyc(); chk("tie_e4_valid", 64'(cdb_valid), 64'd0);

        // ALU stream with LSB idle: one push and one pop per cycle keeps count at 1
        do_reset("tie");
        setup(1, 1, 4, 0);
        for (int i = 0; i < 4; i++) expect_bc(ar[i], ad[i], 1'b0);
        for (int k = 1; k <= 6; k++) begin
            cyc();
            chk($sformatf("fill_e%0d_alu_ready", k), 64'(alu_req_ready), 64'd1);
            chk($sformatf("fill_e%0d_valid", k), 64'(cdb_valid), 64'((k >= 2) && (k <= 5)));
        end
        chk("fill_accepted", 64'(ai), 64'd4);

        // Contention: strict alternation for 8 cycles, full FIFOs back-pressure
        do_reset("fill");
        setup(1, 5, 4, 4);
        for (int i = 0; i < 4; i++) begin
            expect_bc(ar[i], ad[i], 1'b0);
            expect_bc(lr[i], ld[i], 1'b1);
        end
        for (int k = 1; k <= 10; k++) begin
            cyc();
            chk($sformatf("cont_e%0d_valid", k), 64'(cdb_valid), 64'((k >= 2) && (k <= 9)));
            if (k >= 2 && k <= 9)
                chk($sformatf("cont_e%0d_src", k), 64'(cdb_src), 64'(k % 2));
            if (k == 2) begin
                chk("cont_e2_alu_ready", 64'(alu_req_ready), 64'd1);
                chk("cont_e2_lsb_ready", 64'(lsb_req_ready), 64'd0);
            end
            if (k == 3) begin
                chk("cont_e3_alu_ready", 64'(alu_req_ready), 64'd0);
                chk("cont_e3_lsb_ready", 64'(lsb_req_ready), 64'd1);
            end
        end

        // Flush with both FIFOs occupied and a same-cycle push
        do_reset("cont");
        setup(1, 5, 4, 3);
        expect_bc(ar[0], ad[0], 1'b0);
        expect_bc(lr[0], ld[0], 1'b1);
        cyc(); chk("clr_e1_valid", 64'(cdb_valid), 64'd0);
        cyc(); chk("clr_e2_rob", 64'(cdb_rob_index), 64'(ar[0]));
        chk("clr_e2_lsb_ready", 64'(lsb_req_ready), 64'd0);
        cyc(); chk("clr_e3_rob", 64'(cdb_rob_index), 64'(lr[0]));
        chk("clr_e3_alu_ready", 64'(alu_req_ready), 64'd0);
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        an = ai; ln = li;
        chk("clr_e4_valid", 64'(cdb_valid), 64'd0);
        chk("clr_e4_rob", 64'(cdb_rob_index), 64'd0);
        chk("clr_e4_alu_ready", 64'(alu_req_ready), 64'd1);
        chk("clr_e4_lsb_ready", 64'(lsb_req_ready), 64'd1);
        for (int k = 5; k <= 8; k++) begin
            cyc();
            chk($sformatf("clr_e%0d_valid", k), 64'(cdb_valid), 64'd0);
        end

        // rdy_in low for 3 cycles freezes outputs with a result pending
        do_reset("clr");
        setup(9, 10, 1, 1);
        expect_bc(4'd9, 32'hA009, 1'b0);
        expect_bc(4'd10, 32'hB00A, 1'b1);
        cyc();
        cyc(); chk("stall_e2_rob", 64'(cdb_rob_index), 64'd9);
        rdy = 1'b0;
        for (int k = 3; k <= 5; k++) begin
            cyc();
            chk($sformatf("stall_e%0d_valid", k), 64'(cdb_valid), 64'd1);
            chk($sformatf("stall_e%0d_bus", k), {cdb_rob_index, cdb_data, cdb_src}, {4'd9, 32'hA009, 1'b0});
            chk($sformatf("stall_e%0d_ready", k), 64'({alu_req_ready, lsb_req_ready}), 64'd0);
        end
        rdy = 1'b1;
        cyc(); chk("stall_resume_rob", 64'(cdb_rob_index), 64'd10);
        chk("stall_resume_src", 64'(cdb_src), 64'd1);
        cyc(); chk("stall_end_valid", 64'(cdb_valid), 64'd0);

        // Asynchronous reset pulse between edges discards the pending LSB result
        do_reset("stall");
        setup(11, 14, 1, 1);
        expect_bc(4'd11, 32'hA00B, 1'b0);
        cyc();
        cyc(); chk("arst_e2_valid", 64'(cdb_valid), 64'd1);
        #5;
        rst = 1'b1;
        #1;
        chk("arst_mid_valid", 64'(cdb_valid), 64'd0);
        chk("arst_mid_rob", 64'(cdb_rob_index), 64'd0);
        chk("arst_mid_ready", 64'({alu_req_ready, lsb_req_ready}), 64'd3);
        #1;
        rst = 1'b0;
        for (int k = 3; k <= 5; k++) begin
            cyc();
            chk($sformatf("arst_e%0d_valid", k), 64'(cdb_valid), 64'd0);
        end
        chk("sb_drained_final", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
